// File: rtl/vec_fill_engine.sv
// Sequential bit-vector fill engine: rewrites LANES bits of vec per clock (set/clear/invert/pattern).
// Optional self-check enabled by defining VEC_FILL_CHECK_EN (snapshot + expected result + chk_err).
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | writing LANES bits per edge at idx
// S_DONE | one-cycle completion pulse; start here restarts immediately
module vec_fill_engine #(
  parameter int               WIDTH = 8,
  parameter int               LANES = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] vec,
  output logic             chk_err
);

  localparam int IW   = (WIDTH + LANES > 2) ? $clog2(WIDTH + LANES) : 1;
  localparam int N_WR = (WIDTH + LANES - 1) / LANES;
  localparam int CW   = (N_WR > 1) ? $clog2(N_WR) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] vec_n, wr_vec;
  logic [IW-1:0]    idx, idx_n;
  logic [CW-1:0]    rem, rem_n;
  logic [1:0]       mode_q, mode_n;
  logic             dir_q, dir_n;
  logic             accept, last;
  int               idx_i;

  // Lane window starts at idx and extends LANES bits toward the walk direction.
  always_comb begin
    wr_vec = vec;
    idx_i  = int'(idx);
    for (int i = 0; i < WIDTH; i++) begin
      if (dir_q ? ((i <= idx_i) && (i + LANES > idx_i))
                : ((i >= idx_i) && (i < idx_i + LANES))) begin
        case (mode_q)
          2'b00:   wr_vec[i] = 1'b1;
          2'b01:   wr_vec[i] = 1'b0;
          2'b10:   wr_vec[i] = ~vec[i];
          default: wr_vec[i] = ((i % 2) == 1);
        endcase
      end
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    idx_n   = idx;
    rem_n   = rem;
    mode_n  = mode_q;
    dir_n   = dir_q;
    accept  = (state != S_RUN) && start;
    last    = (rem == '0);
    case (state)
      S_RUN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          vec_n = wr_vec;
          if (last) begin
            state_n = S_DONE;
          end else begin
            rem_n = rem - CW'(1);
            idx_n = dir_q ? (idx - IW'(LANES)) : (idx + IW'(LANES));
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (accept) begin
      state_n = S_RUN;
      mode_n  = mode;
      dir_n   = dir;
      idx_n   = dir ? IW'(WIDTH - 1) : '0;
      rem_n   = CW'(N_WR - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      vec    <= INIT;
      idx    <= '0;
      rem    <= '0;
      mode_q <= 2'b00;
      dir_q  <= 1'b0;
    end else begin
      state  <= state_n;
      vec    <= vec_n;
      idx    <= idx_n;
      rem    <= rem_n;
      mode_q <= mode_n;
      dir_q  <= dir_n;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

`ifdef VEC_FILL_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic             chk_q;

  function automatic logic [WIDTH-1:0] full_fill(input logic [1:0] m, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (m)
      2'b00:   r = '1;
      2'b01:   r = '0;
      2'b10:   r = ~v;
      default: begin
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = ((i % 2) == 1);
      end
    endcase
    return r;
  endfunction

  // Expected result is taken from vec as it stands when the start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      chk_q <= 1'b0;
    end else if (accept) begin
      exp_q <= full_fill(mode, vec);
      chk_q <= 1'b0;
    end else if ((state == S_RUN) && !abort && last && (vec_n != exp_q)) begin
      chk_q <= 1'b1;
    end
  end

  assign chk_err = chk_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      if (done) assert (vec == exp_q);
      assert (!(busy && done));
    end
  end
`endif
`else
  assign chk_err = 1'b0;
`endif

endmodule
